// File: rtl/wb_sequencer.sv
// Write-side front end of the register file: merges ALU and load results into one regfile write per cycle.
// Optional WB_BYPASS_EN lets a load returning into an empty queue skip the queue when no ALU write wins.
module wb_sequencer #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     ld_issue,
  input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     stall,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] addr3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam int NREG  = 1 << ADDRESS_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] fifoRd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifoData_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]         wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [NREG-1:0]          pend_q, pend_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] addr3_q, addr3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  logic                     aluWin, ldAccept, fifoEmpty, bypassEn, pushEn, popEn;
  logic [ADDRESS_WIDTH-1:0] headRd;
  logic [DATA_WIDTH-1:0]    headData;

  assign ld_ready  = (count_q < FULL_CNT);
  assign fifoEmpty = (count_q == '0);
  assign aluWin    = alu_valid && (alu_rd != '0);
  assign ldAccept  = ld_valid && ld_ready && (ld_rd != '0);
  assign headRd    = fifoRd_q[rdPtr_q];
  assign headData  = fifoData_q[rdPtr_q];

`ifdef WB_BYPASS_EN
  assign bypassEn = ldAccept && fifoEmpty && !aluWin;
`else
  assign bypassEn = 1'b0;
`endif

  // A bypassed load never enters the queue; readiness is judged on the pre-pop count.
  assign pushEn = ldAccept && !bypassEn;
  assign popEn  = !aluWin && !fifoEmpty;

  assign stall = pend_q[rs1] | pend_q[rs2];
  assign we3   = we3_q;
  assign addr3 = addr3_q;
  assign wd3   = wd3_q;

  always_comb begin
    we3_d   = 1'b0;
    addr3_d = addr3_q;
    wd3_d   = wd3_q;
    if (aluWin) begin
      we3_d   = 1'b1;
      addr3_d = alu_rd;
      wd3_d   = alu_data;
    end else if (popEn) begin
      we3_d   = 1'b1;
      addr3_d = headRd;
      wd3_d   = headData;
    end else if (bypassEn) begin
      we3_d   = 1'b1;
      addr3_d = ld_rd;
      wd3_d   = ld_data;
    end
  end

  always_comb begin
    rdPtr_d = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    wrPtr_d = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    count_d = count_q;
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clears are applied before the issue set so a same-cycle set of the same rd wins.
  always_comb begin
    pend_d = pend_q;
    if (popEn)
      pend_d[headRd] = 1'b0;
    if (bypassEn)
      pend_d[ld_rd] = 1'b0;
    if (ld_issue)
      pend_d[ld_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      pend_q  <= '0;
      we3_q   <= 1'b0;
      addr3_q <= '0;
      wd3_q   <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      we3_q   <= we3_d;
      addr3_q <= addr3_d;
      wd3_q   <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pushEn) begin
      fifoRd_q[wrPtr_q]   <= ld_rd;
      fifoData_q[wrPtr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios plus random traffic against a queue-based model.
// Define WB_BYPASS_EN for both this file and the RTL to check the bypass build.
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1, rs2;
  logic        stall;
  logic        we3;
  logic [4:0]  addr3;
  logic [31:0] wd3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      mQueue[$];
  bit   [31:0] mPend;
  logic        mWe3;
  logic [4:0]  mAddr3;
  logic [31:0] mWd3;

  wb_sequencer #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .we3(we3), .addr3(addr3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: one regfile write per cycle, ALU first, then the oldest queued load.
  task automatic modelStep();
    bit     aluWin, accept, bypass;
    entry_t e;
    if (rst) begin
      mQueue.delete();
      mPend  = '0;
      mWe3   = 1'b0;
      mAddr3 = '0;
      mWd3   = '0;
      return;
    end
    aluWin = alu_valid && alu_rd != 0;
    accept = ld_valid && mQueue.size() < 4 && ld_rd != 0;
`ifdef WB_BYPASS_EN
    bypass = accept && mQueue.size() == 0 && !aluWin;
`else
    bypass = 1'b0;
`endif
    mWe3 = 1'b1;
    if (aluWin) begin
      mAddr3 = alu_rd;
      mWd3   = alu_data;
    end else if (mQueue.size() > 0) begin
      e = mQueue.pop_front();
      mAddr3 = e.rd;
      mWd3   = e.data;
      mPend[e.rd] = 1'b0;
    end else if (bypass) begin
      mAddr3 = ld_rd;
      mWd3   = ld_data;
      mPend[ld_rd] = 1'b0;
    end else begin
      mWe3 = 1'b0;
    end
    if (accept && !bypass) begin
      e.rd   = ld_rd;
      e.data = ld_data;
      mQueue.push_back(e);
    end
    if (ld_issue && ld_issue_rd != 0)
      mPend[ld_issue_rd] = 1'b1;
  endtask

  // Inputs are already driven; check combinational outputs, advance one edge, check registered outputs.
  task automatic applyStimulus();
    #1;
    checkOutput("ld_ready", ld_ready, (mQueue.size() < 4) ? 1 : 0);
    checkOutput("stall", stall, (mPend[rs1] | mPend[rs2]) ? 1 : 0);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("we3", we3, mWe3);
    checkOutput("addr3", addr3, mAddr3);
    checkOutput("wd3", wd3, mWd3);
  endtask

  task automatic clearInputs();
    rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic randomInputs();
    alu_valid   = ($urandom_range(0, 1) == 1);
    alu_rd      = 5'($urandom_range(0, 15));
    alu_data    = $urandom;
    ld_issue    = ($urandom_range(0, 2) == 0);
    ld_issue_rd = 5'($urandom_range(0, 15));
    ld_valid    = ($urandom_range(0, 4) < 2);
    ld_rd       = 5'($urandom_range(0, 15));
    ld_data     = $urandom;
    rs1         = 5'($urandom_range(0, 15));
    rs2         = 5'($urandom_range(0, 15));
  endtask

  initial begin
    clearInputs();
    mQueue.delete();
    mPend = '0; mWe3 = 0; mAddr3 = 0; mWd3 = 0;

    // Reset with random inputs; the first edge only brings the DUT out of X.
    randomInputs();
    rst = 1;
    @(posedge clk);
    #1;
    randomInputs();
    rst = 1;
    applyStimulus();
    checkOutput("rst_we3", we3, 0);
    checkOutput("rst_addr3", addr3, 0);
    checkOutput("rst_wd3", wd3, 0);
    checkOutput("rst_ld_ready", ld_ready, 1);
    checkOutput("rst_stall", stall, 0);

    clearInputs();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("alu_we3", we3, 1);
    checkOutput("alu_addr3", addr3, 5);
    checkOutput("alu_wd3", wd3, 32'hDEADBEEF);
    alu_rd = 0;
    applyStimulus();
    checkOutput("alu_x0_we3", we3, 0);

    // ALU keeps the port for three cycles; the load on x7 lands on the fourth.
    clearInputs();
    ld_valid = 1; ld_rd = 7; ld_data = 1;
    alu_valid = 1; alu_rd = 3; alu_data = 2;
    applyStimulus();
    checkOutput("prio_c1_addr3", addr3, 3);
    ld_valid = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("prio_c3_addr3", addr3, 3);
    alu_valid = 0;
    applyStimulus();
    checkOutput("prio_c4_we3", we3, 1);
    checkOutput("prio_c4_addr3", addr3, 7);
    checkOutput("prio_c4_wd3", wd3, 1);

    // Fill the queue behind a busy ALU, then drain it.
    clearInputs();
    alu_valid = 1; alu_rd = 10; alu_data = 32'h0A0A0A0A;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1; ld_rd = 5'(i); ld_data = 32'(100 + i);
      applyStimulus();
    end
    checkOutput("full_ld_ready", ld_ready, 0);
    ld_rd = 5; ld_data = 32'd105;
    applyStimulus();
    ld_valid = 0; alu_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput("drain_addr3", addr3, 5'(i));
      checkOutput("drain_wd3", wd3, 32'(100 + i));
      if (i == 1)
        checkOutput("drain_ready", ld_ready, 1);
    end
    applyStimulus();
    checkOutput("drain_idle_we3", we3, 0);

    // Scoreboard: pending x9 stalls decode until its load is written, re-issue keeps it pending.
    clearInputs();
    rs1 = 9;
    ld_issue = 1; ld_issue_rd = 9;
    applyStimulus();
    ld_issue = 0;
    checkOutput("sb_stall_set", stall, 1);
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
`ifdef WB_BYPASS_EN
    ld_issue = 1;
`endif
    applyStimulus();
    ld_valid = 0;
`ifndef WB_BYPASS_EN
    ld_issue = 1;
    applyStimulus();
`endif
    ld_issue = 0;
    checkOutput("sb_x9_write", addr3, 9);
    checkOutput("sb_stall_kept", stall, 1);
    ld_valid = 1; ld_rd = 9; ld_data = 32'h98;
    applyStimulus();
    ld_valid = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("sb_stall_cleared", stall, 0);

`ifdef WB_BYPASS_EN
    clearInputs();
    ld_valid = 1; ld_rd = 12; ld_data = 5;
    applyStimulus();
    checkOutput("byp_we3", we3, 1);
    checkOutput("byp_addr3", addr3, 12);
    checkOutput("byp_wd3", wd3, 5);
`endif

    // Random traffic with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      randomInputs();
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
